// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus AXI-Stream TX/RX channels of spi_slave
//   spi_clk, spi_cs, spi_mosi : from the SPI master (cs active low)
//   spi_miso, spi_miso_oe     : to the SPI master
//   s_axis_*                  : TX words from the fabric
//   m_axis_*                  : RX words to the fabric
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  spi_clk;
    logic                  spi_cs;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport slave (
        input  spi_clk, spi_cs, spi_mosi, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output spi_miso, spi_miso_oe, s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport master (
        output spi_clk, spi_cs, spi_mosi, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  spi_miso, spi_miso_oe, s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI responder oversampled on aclk, LSB-first words exchanged over AXI-Stream
//   aclk, aresetn      : system clock, asynchronous active-low reset
//   bus                : SPI pins and TX (s_axis_*) / RX (m_axis_*) streams
//   busy               : frame in progress
//   overrun, underrun  : one-cycle pulses for a dropped RX word / a TX load from an empty holding register
module spi_slave #(
    parameter int   DATA_WIDTH  = 8,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic       aclk,
    input  logic       aresetn,
    spi_slave_if.slave bus,
    output logic       busy,
    output logic       overrun,
    output logic       underrun
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                  sclk_q, cs_q, sclk_s, cs_s, mosi_s;
    logic                  rise, fall, sample_edge, shift_edge, cs_fall;
    logic                  sample, shift, shift_ev, load, done;
    logic                  first, hold_full, rx_valid;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] hold, tx_shift, rx_shift, rx_word, rx_data;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_q;
    assign fall    = ~sclk_s & sclk_q;
    // CPOL^CPHA selects which physical edge samples; the other one shifts
    assign sample_edge = (CPOL ^ CPHA) ? fall : rise;
    assign shift_edge  = (CPOL ^ CPHA) ? rise : fall;
    assign cs_fall = cs_q & ~cs_s;
    assign rx_word = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
    assign done    = sample && cnt == CW'(DATA_WIDTH - 1);
    // a shift edge at bit 0 starts a new word: load, except the very first one of a frame
    assign shift   = shift_ev && cnt != '0;

    assign busy              = state == ACTIVE;
    assign bus.spi_miso      = tx_shift[0];
    assign bus.spi_miso_oe   = busy;
    assign bus.s_axis_tready = !hold_full;
    assign bus.m_axis_tdata  = rx_data;
    assign bus.m_axis_tvalid = rx_valid;

    // CS resets low so a frame already running at reset release is ignored until CS is seen high
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_q    <= CPOL;
            cs_q      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        sample     = 1'b0;
        shift_ev   = 1'b0;
        if (cs_s) begin
            state_next = IDLE;
        end else if (state == IDLE) begin
            state_next = cs_fall ? ACTIVE : IDLE;
            load       = cs_fall;
        end else begin
            sample   = sample_edge;
            shift_ev = shift_edge;
            load     = shift_edge && cnt == '0 && !first;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt       <= '0;
            first     <= 1'b0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            cnt   <= (state_next == IDLE || done) ? '0 : sample ? cnt + 1'b1 : cnt;
            first <= (state == IDLE) ? 1'b1 : shift_ev ? 1'b0 : first;
            if (sample) rx_shift <= rx_word;
            if (load) tx_shift <= hold_full ? hold : '0;
            else if (shift) tx_shift <= tx_shift >> 1;
            if (bus.s_axis_tvalid && !hold_full) begin
                hold      <= bus.s_axis_tdata;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            underrun <= load && !hold_full;
            overrun  <= done && rx_valid && !bus.m_axis_tready;
            if (done && (!rx_valid || bus.m_axis_tready)) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (bus.m_axis_tready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule
